// File: rtl/xge_pkt_tx_arbiter.sv
// rtl/xge_pkt_tx_arbiter.sv - round-robin whole-packet arbiter onto the 10GE MAC pkt_tx interface
module xge_pkt_tx_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int CNT_W  = 32
) (
    input  logic                  clk_156m25,
    input  logic                  reset_156m25_n,
    input  logic [NUM_CH-1:0]     ch_val,
    input  logic [NUM_CH-1:0]     ch_sop,
    input  logic [NUM_CH-1:0]     ch_eop,
    input  logic [64*NUM_CH-1:0]  ch_data,
    input  logic [3*NUM_CH-1:0]   ch_mod,
    output logic [NUM_CH-1:0]     ch_rdy,
    input  logic                  pkt_tx_full,
    output logic                  pkt_tx_val,
    output logic                  pkt_tx_sop,
    output logic                  pkt_tx_eop,
    output logic [63:0]           pkt_tx_data,
    output logic [2:0]            pkt_tx_mod,
    output logic [CH_W-1:0]       cur_ch,
    output logic                  busy,
    output logic                  err_proto,
    output logic [CNT_W-1:0]      pkt_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]       state_q,   state_d;
    logic [CH_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [CH_W-1:0]  cur_ch_q,  cur_ch_d;
    logic             first_q,   first_d;
    logic             tx_val_q,  tx_val_d;
    logic             tx_sop_q,  tx_sop_d;
    logic             tx_eop_q,  tx_eop_d;
    logic [63:0]      tx_data_q, tx_data_d;
    logic [2:0]       tx_mod_q,  tx_mod_d;
    logic             err_q,     err_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic [NUM_CH-1:0] req;
    logic              grant_vld;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W:0]     idx_w;
    logic [63:0]       cur_data;
    logic [2:0]        cur_mod;
    logic              cur_sop;
    logic              cur_eop;
    logic              accept;
    logic              discard;

    assign req      = ch_val & ch_sop;
    assign cur_data = ch_data[64*int'(cur_ch_q) +: 64];
    assign cur_mod  = ch_mod[3*int'(cur_ch_q) +: 3];
    assign cur_sop  = ch_sop[cur_ch_q];
    assign cur_eop  = ch_eop[cur_ch_q];
    assign accept   = reset_156m25_n && (state_q == ST_XFER) && ch_val[cur_ch_q] && !pkt_tx_full;
    assign discard  = (state_q == ST_IDLE) && (|(ch_val & ~ch_sop));

    // Round-robin search: walk offsets downward so the smallest offset from rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx_w     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx_w = {1'b0, rr_ptr_q} + (CH_W + 1)'(i);
            if (idx_w >= (CH_W + 1)'(NUM_CH)) begin
                idx_w = idx_w - (CH_W + 1)'(NUM_CH);
            end
            if (req[idx_w[CH_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_ch  = idx_w[CH_W-1:0];
            end
        end
    end

    // Beat accept: IDLE swallows stray non-sop beats, XFER opens only the granted channel.
    always_comb begin
        ch_rdy = '0;
        if (!reset_156m25_n) begin
            ch_rdy = '0;
        end else if (state_q == ST_IDLE) begin
            ch_rdy = ch_val & ~ch_sop;
        end else begin
            ch_rdy[cur_ch_q] = !pkt_tx_full;
        end
    end

    // Next-state: grant in IDLE, forward accepted beats in XFER, flag protocol violations.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_ch_d  = cur_ch_q;
        first_d   = first_q;
        tx_val_d  = 1'b0;
        tx_sop_d  = 1'b0;
        tx_eop_d  = 1'b0;
        tx_data_d = '0;
        tx_mod_d  = '0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        if (state_q == ST_IDLE) begin
            err_d = discard;
            if (grant_vld) begin
                state_d  = ST_XFER;
                cur_ch_d = grant_ch;
                first_d  = 1'b1;
                if (grant_ch == CH_W'(NUM_CH - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_ch + 1'b1;
                end
            end
        end else if (accept) begin
            tx_val_d  = 1'b1;
            tx_sop_d  = first_q;
            tx_data_d = cur_data;
            first_d   = 1'b0;
            err_d     = cur_sop && !first_q;
            if (cur_eop) begin
                tx_eop_d = 1'b1;
                tx_mod_d = cur_mod;
                cnt_d    = cnt_q + 1'b1;
                state_d  = ST_IDLE;
            end
        end
    end

    // State and registered MAC-side outputs; reset abandons any partial packet.
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            cur_ch_q  <= '0;
            first_q   <= 1'b0;
            tx_val_q  <= 1'b0;
            tx_sop_q  <= 1'b0;
            tx_eop_q  <= 1'b0;
            tx_data_q <= '0;
            tx_mod_q  <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_ch_q  <= cur_ch_d;
            first_q   <= first_d;
            tx_val_q  <= tx_val_d;
            tx_sop_q  <= tx_sop_d;
            tx_eop_q  <= tx_eop_d;
            tx_data_q <= tx_data_d;
            tx_mod_q  <= tx_mod_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pkt_tx_val  = tx_val_q;
    assign pkt_tx_sop  = tx_sop_q;
    assign pkt_tx_eop  = tx_eop_q;
    assign pkt_tx_data = tx_data_q;
    assign pkt_tx_mod  = tx_mod_q;
    assign cur_ch      = cur_ch_q;
    assign busy        = (state_q == ST_XFER);
    assign err_proto   = err_q;
    assign pkt_count   = cnt_q;

endmodule
